// File: rtl/vga_pkg.sv
// vga_pkg: types and defaults shared along the VGA overlay chain.
// Screen select enum used by game_screen_ctrl and the overlay drawer.
package vga_pkg;

  typedef enum logic [1:0] {
    SCREEN_START  = 2'd0,
    SCREEN_PLAY   = 2'd1,
    SCREEN_FINISH = 2'd2
  } screen_t;

  localparam logic [11:0] GOAL_X_MIN_DEF = 12'd500;
  localparam logic [11:0] GOAL_X_MAX_DEF = 12'd700;
  localparam logic [11:0] GOAL_Y_MIN_DEF = 12'd100;
  localparam logic [11:0] GOAL_Y_MAX_DEF = 12'd112;
  localparam logic [1:0]  FINISH_LVL_DEF = 2'b11;

  localparam int unsigned GOAL_FRAMES_DEF   = 4;
  localparam int unsigned START_FRAMES_DEF  = 3;
  localparam int unsigned FINISH_FRAMES_DEF = 600;

  // Open rectangle test: edges themselves are outside.
  function automatic logic in_region(
    input logic [11:0] x,
    input logic [11:0] y,
    input logic [11:0] x_min,
    input logic [11:0] x_max,
    input logic [11:0] y_min,
    input logic [11:0] y_max
  );
    return (x > x_min) && (x < x_max) &&
           (y > y_min) && (y < y_max);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle pulse per rising edge of vblnk.
// Ports: clk, rst (async active-low), vblnk in; frame_tick out.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic frame_tick
);

  logic vblnk_d;
  logic primed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_d    <= 1'b0;
      primed     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vblnk_d    <= vblnk;
      primed     <= 1'b1;
      // The first sample after reset only seeds vblnk_d,
      // so a vblnk already high at release is not an edge.
      frame_tick <= primed & vblnk & ~vblnk_d;
    end
  end

endmodule

// File: rtl/game_screen_ctrl.sv
// game_screen_ctrl: frame-synchronous START/PLAY/FINISH sequencer.
// In: clk, rst(async low), vblnk, start_btn, level, x/y_value.
// Out: screen, game_en, game_rst, frame_tick.
module game_screen_ctrl
  import vga_pkg::*;
#(
  parameter logic [11:0] GOAL_X_MIN    = GOAL_X_MIN_DEF,
  parameter logic [11:0] GOAL_X_MAX    = GOAL_X_MAX_DEF,
  parameter logic [11:0] GOAL_Y_MIN    = GOAL_Y_MIN_DEF,
  parameter logic [11:0] GOAL_Y_MAX    = GOAL_Y_MAX_DEF,
  parameter logic [1:0]  FINISH_LEVEL  = FINISH_LVL_DEF,
  parameter int unsigned GOAL_FRAMES   = GOAL_FRAMES_DEF,
  parameter int unsigned START_FRAMES  = START_FRAMES_DEF,
  parameter int unsigned FINISH_FRAMES = FINISH_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start_btn,
  input  logic [1:0]  level,
  input  logic [11:0] x_value,
  input  logic [11:0] y_value,
  output screen_t     screen,
  output logic        game_en,
  output logic        game_rst,
  output logic        frame_tick
);

  localparam int SW = $clog2(START_FRAMES + 1);
  localparam int GW = $clog2(GOAL_FRAMES + 1);
  localparam int FW = $clog2(FINISH_FRAMES + 1);

  localparam logic [SW-1:0] START_MAX = SW'(START_FRAMES);
  localparam logic [GW-1:0] GOAL_MAX  = GW'(GOAL_FRAMES);
  localparam logic [FW-1:0] FIN_MAX   = FW'(FINISH_FRAMES);

  typedef enum logic [1:0] {
    S_START,
    S_PLAY,
    S_FINISH,
    S_RESTART
  } state_t;

  state_t        state;
  logic          armed;
  logic [SW-1:0] start_cnt;
  logic [GW-1:0] goal_cnt;
  logic [FW-1:0] fin_cnt;

  logic [SW-1:0] start_inc;
  logic [GW-1:0] goal_inc;
  logic [FW-1:0] fin_inc;
  logic          in_goal;

  frame_tick_gen u_tick (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .frame_tick (frame_tick)
  );

  assign in_goal = (level == FINISH_LEVEL) &&
                   in_region(x_value, y_value,
                             GOAL_X_MIN, GOAL_X_MAX,
                             GOAL_Y_MIN, GOAL_Y_MAX);

  // Saturating increments; each counter stops at its limit.
  always_comb begin
    start_inc = start_cnt;
    goal_inc  = goal_cnt;
    fin_inc   = fin_cnt;
    if (start_cnt != START_MAX) start_inc = start_cnt + 1'b1;
    if (goal_cnt != GOAL_MAX)   goal_inc  = goal_cnt + 1'b1;
    if (fin_cnt != FIN_MAX)     fin_inc   = fin_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_START;
      screen    <= SCREEN_START;
      game_en   <= 1'b0;
      game_rst  <= 1'b0;
      armed     <= 1'b0;
      start_cnt <= '0;
      goal_cnt  <= '0;
      fin_cnt   <= '0;
    end else begin
      game_rst <= 1'b0;
      unique case (state)
        S_START: begin
          if (frame_tick) begin
            if (!start_btn) begin
              // Button must be seen released before it counts.
              armed     <= 1'b1;
              start_cnt <= '0;
            end else if (armed) begin
              if (start_inc == START_MAX) begin
                state     <= S_PLAY;
                screen    <= SCREEN_PLAY;
                game_en   <= 1'b1;
                start_cnt <= '0;
                goal_cnt  <= '0;
                fin_cnt   <= '0;
              end else begin
                start_cnt <= start_inc;
              end
            end
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (!in_goal) begin
              goal_cnt <= '0;
            end else if (goal_inc == GOAL_MAX) begin
              state     <= S_FINISH;
              screen    <= SCREEN_FINISH;
              game_en   <= 1'b0;
              start_cnt <= '0;
              goal_cnt  <= '0;
              fin_cnt   <= '0;
            end else begin
              goal_cnt <= goal_inc;
            end
          end
        end
        S_FINISH: begin
          if (frame_tick) begin
            if (fin_inc == FIN_MAX) begin
              state     <= S_RESTART;
              screen    <= SCREEN_START;
              game_en   <= 1'b0;
              game_rst  <= 1'b1;
              start_cnt <= '0;
              goal_cnt  <= '0;
              fin_cnt   <= '0;
            end else begin
              fin_cnt <= fin_inc;
            end
          end
        end
        S_RESTART: begin
          // Single cycle, independent of frame_tick.
          state     <= S_START;
          screen    <= SCREEN_START;
          game_en   <= 1'b0;
          armed     <= 1'b0;
          start_cnt <= '0;
          goal_cnt  <= '0;
          fin_cnt   <= '0;
        end
        default: begin
          state  <= S_START;
          screen <= SCREEN_START;
        end
      endcase
    end
  end

endmodule
